// File: rtl/aes_enc_round.sv
// aes_enc_round: one forward AES-128 round (SubBytes, ShiftRows, MixColumns,
// AddRoundKey) as a 4-stage valid/ready pipeline with a global stall.
// Optional feature macro: AES_ENC_FINAL_ROUND_EN adds in_last/out_last and
// lets the final round skip MixColumns; without it MixColumns always runs.
//
// Handshake: a block is accepted when in_valid && in_ready, and leaves when
// out_valid && out_ready. One advance enable (adv = !out_valid || out_ready)
// moves every stage at once; in_ready = adv and never looks at in_valid.
// When adv=0 the whole pipe, including the key line and valid bits, holds.
module aes_enc_round #(
    parameter int SBOX_STAGES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] round_input,
    input  logic [127:0] key,
`ifdef AES_ENC_FINAL_ROUND_EN
    input  logic         in_last,
    output logic         out_last,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] round_output
);

    // The SubBytes split is LUT-then-delay: stage 1 does the lookup, stages 2
    // and 3 carry it. Any other depth would break the 4-cycle latency.
    generate
        if (SBOX_STAGES != 3) begin : g_bad_sbox_stages
            $error("aes_enc_round: SBOX_STAGES must be 3");
        end
    endgenerate

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox(x[8*i +: 8]);
        return y;
    endfunction

    // ShiftRows, then MixColumns (bypassed when last), then AddRoundKey.
    // Byte index i = 4*col + row, byte 0 at [127:120].
    function automatic logic [127:0] round_fn(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic         last);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [127:0] sr_w;
        logic [127:0] mc_w;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = b[4*((c+r)%4)+r];
        for (int i = 0; i < 16; i++) sr_w[127-8*i -: 8] = sr[i];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc_w[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return (last ? sr_w : mc_w) ^ k;
    endfunction

    logic         adv;
    logic         v1, v2, v3;
    logic [127:0] s1_data, s2_data, s3_data;
    logic [127:0] k1, k2, k3;
    logic         s3_last;

    // Global advance enable; input readiness is exactly that enable.
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    // Data/key pipeline; data registers only load behind a valid bit so
    // bubbles keep whatever they held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            out_valid    <= 1'b0;
            s1_data      <= '0;
            s2_data      <= '0;
            s3_data      <= '0;
            k1           <= '0;
            k2           <= '0;
            k3           <= '0;
            round_output <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (in_valid) begin
                s1_data <= sub_bytes(round_input);
                k1      <= key;
            end
            if (v1) begin
                s2_data <= s1_data;
                k2      <= k1;
            end
            if (v2) begin
                s3_data <= s2_data;
                k3      <= k2;
            end
            if (v3) round_output <= round_fn(s3_data, k3, s3_last);
        end
    end

`ifdef AES_ENC_FINAL_ROUND_EN
    logic l1, l2, l3;

    // Final-round flag delay line, aligned with the data stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1       <= 1'b0;
            l2       <= 1'b0;
            l3       <= 1'b0;
            out_last <= 1'b0;
        end else if (adv) begin
            if (in_valid) l1 <= in_last;
            if (v1) l2 <= l1;
            if (v2) l3 <= l2;
            if (v3) out_last <= l3;
        end
    end

    assign s3_last = l3;
`else
    assign s3_last = 1'b0;
`endif

endmodule
